// File: rtl/mux4x1_pkg.sv
// rtl/mux4x1_pkg.sv - select encodings and default width for the registered 4:1 mux
package mux4x1_pkg;

  localparam logic [1:0] SEL_A = 2'b00;
  localparam logic [1:0] SEL_B = 2'b01;
  localparam logic [1:0] SEL_C = 2'b10;
  localparam logic [1:0] SEL_D = 2'b11;

  localparam int DEFAULT_WIDTH = 2;

endpackage

// File: rtl/mux4_bit_gate.sv
// rtl/mux4_bit_gate.sv - one-bit 4:1 mux from AND/OR/NOT primitives
module mux4_bit_gate (
  input  logic i0,
  input  logic i1,
  input  logic i2,
  input  logic i3,
  input  logic s1,
  input  logic s0,
  output logic y
);

  logic ns1;
  logic ns0;
  logic t0;
  logic t1;
  logic t2;
  logic t3;

  not g_ns1 (ns1, s1);
  not g_ns0 (ns0, s0);

  // One product term per select code; exactly one term is enabled for a known sel.
  and g_t0 (t0, i0, ns1, ns0);
  and g_t1 (t1, i1, ns1, s0);
  and g_t2 (t2, i2, s1,  ns0);
  and g_t3 (t3, i3, s1,  s0);

  or  g_y  (y, t0, t1, t2, t3);

endmodule

// File: rtl/mux4x1_2b_reg.sv
// rtl/mux4x1_2b_reg.sv - registered 4:1 mux; MUX4X1_PARITY_EN adds registered out_par
module mux4x1_2b_reg
  import mux4x1_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] c,
  input  logic [WIDTH-1:0] d,
  input  logic [1:0]       sel,
  input  logic             in_vld,
  output logic [WIDTH-1:0] out,
`ifdef MUX4X1_PARITY_EN
  output logic             out_par,
`endif
  output logic             out_vld
);

  logic [WIDTH-1:0] sel_data;

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    mux4_bit_gate u_bit (
      .i0 (a[i]),
      .i1 (b[i]),
      .i2 (c[i]),
      .i3 (d[i]),
      .s1 (sel[1]),
      .s0 (sel[0]),
      .y  (sel_data[i])
    );
  end

  // The gate network may glitch between edges; only the flopped value is visible.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out     <= '0;
      out_vld <= 1'b0;
    end else begin
      out_vld <= in_vld;
      if (in_vld) begin
        out <= sel_data;
      end
    end
  end

`ifdef MUX4X1_PARITY_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_par <= 1'b0;
    end else if (in_vld) begin
      out_par <= ^sel_data;
    end
  end
`endif

endmodule

// File: tb/tb_mux4x1_2b_reg.sv
// tb/tb_mux4x1_2b_reg.sv - directed self-checking bench for mux4x1_2b_reg
module tb_mux4x1_2b_reg;
  import mux4x1_pkg::*;

  localparam int WIDTH = 2;

  logic             clk;
  logic             rst;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [WIDTH-1:0] c;
  logic [WIDTH-1:0] d;
  logic [1:0]       sel;
  logic             in_vld;
  logic [WIDTH-1:0] out;
  logic             out_vld;
`ifdef MUX4X1_PARITY_EN
  logic             out_par;
`endif

  int n_checks;
  int n_fail;

  mux4x1_2b_reg #(.WIDTH(WIDTH)) dut (
    .clk     (clk),
    .rst     (rst),
    .a       (a),
    .b       (b),
    .c       (c),
    .d       (d),
    .sel     (sel),
    .in_vld  (in_vld),
    .out     (out),
`ifdef MUX4X1_PARITY_EN
    .out_par (out_par),
`endif
    .out_vld (out_vld)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    logic [1:0] sweep_sel [4];
    logic [1:0] exp_a     [4];
    logic [1:0] exp_b     [4];
    n_checks = 0;
    n_fail   = 0;
    sweep_sel = '{SEL_A, SEL_B, SEL_C, SEL_D};
    exp_a     = '{2'b00, 2'b01, 2'b10, 2'b11};
    exp_b     = '{2'b10, 2'b01, 2'b11, 2'b00};

    // Asynchronous reset observed before the first clock edge at t=5
    rst = 1'b0; a = 2'b00; b = 2'b01; c = 2'b10; d = 2'b11; sel = SEL_A; in_vld = 1'b1;
    #2 rst = 1'b1;
    #1;
    check("reset_out", out, 2'b00);
    check("reset_vld", out_vld, 1'b0);
    step();
    check("reset_hold_out", out, 2'b00);
    check("reset_hold_vld", out_vld, 1'b0);
    rst = 1'b0;

    // Select sweep
    for (int i = 0; i < 4; i++) begin
      sel = sweep_sel[i];
      step();
      check($sformatf("sweep_out_%0d", i), out, exp_a[i]);
      check($sformatf("sweep_vld_%0d", i), out_vld, 1'b1);
    end

    // Hold with in_vld low after capturing sel=11
    in_vld = 1'b0;
    sel    = SEL_A;
    for (int i = 0; i < 3; i++) begin
      step();
      check($sformatf("hold_out_%0d", i), out, 2'b11);
      check($sformatf("hold_vld_%0d", i), out_vld, 1'b0);
    end

    // Bit independence
    a = 2'b10; b = 2'b01; c = 2'b11; d = 2'b00; in_vld = 1'b1;
    for (int i = 0; i < 4; i++) begin
      sel = sweep_sel[i];
      step();
      check($sformatf("bits_out_%0d", i), out, exp_b[i]);
      check($sformatf("bits_vld_%0d", i), out_vld, 1'b1);
    end

    // Mid-stream reset: short pulse between edges, then a fresh capture
    sel = SEL_B;
    step();
    check("mid_pre_out", out, 2'b01);
    sel = SEL_C;
    #1 rst = 1'b1;
    #1;
    check("mid_rst_out", out, 2'b00);
    check("mid_rst_vld", out_vld, 1'b0);
    #2 rst = 1'b0;
    #0.5;
    check("mid_release_out", out, 2'b00);
    @(negedge clk);
    check("mid_recap_out", out, 2'b11);
    check("mid_recap_vld", out_vld, 1'b1);

    // Simultaneous data and sel change between edges: sampled value wins
    a = 2'b01; sel = SEL_A;
    step();
    check("simul_out", out, 2'b01);

`ifdef MUX4X1_PARITY_EN
    a = 2'b00; b = 2'b01; c = 2'b10; d = 2'b11;
    sel = SEL_C;
    step();
    check("par_c_out", out, 2'b10);
    check("par_c", out_par, 1'b1);
    sel = SEL_D;
    step();
    check("par_d_out", out, 2'b11);
    check("par_d", out_par, 1'b0);
    in_vld = 1'b0; sel = SEL_C;
    step();
    check("par_hold", out_par, 1'b0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
